// File: rtl/mux_pkg.sv
// Shared definitions for the arbitrated N-channel mux: mode encoding and
// channel-index width derivation.
package mux_pkg;

  typedef enum logic {
    MODE_FIXED       = 1'b0,
    MODE_ROUND_ROBIN = 1'b1
  } mode_e;

  // Index width is clog2 of the channel count, never narrower than one bit.
  function automatic int sel_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/round_robin_priority_encoder_module.sv
// Rotating find-first: returns the first asserted request at or after ptr,
// wrapping modulo CHANNELS.
module round_robin_priority_encoder_module
  import mux_pkg::*;
#(
  parameter  int CHANNELS = 16,
  localparam int SEL_W    = sel_w(CHANNELS)
) (
  input  logic [CHANNELS-1:0] req,
  input  logic [SEL_W-1:0]    ptr,
  output logic [SEL_W-1:0]    grant,
  output logic                found
);

  localparam int unsigned N = CHANNELS;

  always_comb begin
    int unsigned idx;
    idx   = 0;
    grant = '0;
    found = 1'b0;
    // ptr never exceeds N-1, so a single conditional subtract wraps the scan.
    for (int unsigned i = 0; i < N; i++) begin
      idx = 32'(ptr) + i;
      if (idx >= N) idx = idx - N;
      if (!found && req[idx]) begin
        found = 1'b1;
        grant = idx[SEL_W-1:0];
      end
    end
  end

endmodule

// File: rtl/arbitrated_n_channel_mux_module.sv
// N-channel valid/ready mux with fixed-select or round-robin arbitration and
// a single registered output stage that sustains one word per cycle.
module arbitrated_n_channel_mux_module
  import mux_pkg::*;
#(
  parameter  int BITS     = 32,
  parameter  int CHANNELS = 16,
  localparam int SEL_W    = sel_w(CHANNELS)
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic [CHANNELS-1:0][BITS-1:0]  data,
  input  logic [CHANNELS-1:0]            valid,
  output logic [CHANNELS-1:0]            ready,
  input  logic                           mode,
  input  logic [SEL_W-1:0]               select,
  output logic [BITS-1:0]                out,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [SEL_W-1:0]               out_channel
);

  localparam logic [SEL_W:0]   CH_LIM  = (SEL_W + 1)'(CHANNELS);
  localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(CHANNELS - 1);

  logic [SEL_W-1:0] ptr;
  logic [SEL_W-1:0] rr_grant;
  logic             rr_found;
  logic [SEL_W-1:0] grant;
  logic             grant_ok;
  logic             load;
  logic             xfer;

  round_robin_priority_encoder_module #(
    .CHANNELS (CHANNELS)
  ) u_rr_enc (
    .req   (valid),
    .ptr   (ptr),
    .grant (rr_grant),
    .found (rr_found)
  );

  always_comb begin
    grant    = rr_grant;
    grant_ok = 1'b0;
    if (mode == MODE_ROUND_ROBIN) begin
      grant_ok = rr_found;
    end else begin
      grant = select;
      if ({1'b0, select} < CH_LIM) grant_ok = valid[select];
    end
  end

  assign load = !out_valid || out_ready;
  // Gated by reset_n so no accept strobe leaks out while reset is held.
  assign xfer = load && grant_ok && reset_n;

  always_comb begin
    ready = '0;
    if (xfer) ready[grant] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out         <= '0;
      out_valid   <= 1'b0;
      out_channel <= '0;
      ptr         <= '0;
    end else begin
      if (xfer) begin
        out         <= data[grant];
        out_channel <= grant;
        out_valid   <= 1'b1;
        if (mode == MODE_ROUND_ROBIN)
          ptr <= (grant == LAST_CH) ? '0 : grant + 1'b1;
      end else if (load) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_arbitrated_n_channel_mux_module.sv
// Directed and randomized checks of the arbitrated mux against a behavioural
// model of the grant/transfer rules.
module tb_arbitrated_n_channel_mux_module;

  localparam int BITS     = 8;
  localparam int CHANNELS = 16;
  localparam int SEL_W    = 4;

  logic                          clk = 1'b0;
  logic                          reset_n;
  logic [CHANNELS-1:0][BITS-1:0] data;
  logic [CHANNELS-1:0]           valid;
  logic [CHANNELS-1:0]           ready;
  logic                          mode;
  logic [SEL_W-1:0]              select;
  logic [BITS-1:0]               out;
  logic                          out_valid;
  logic                          out_ready;
  logic [SEL_W-1:0]              out_channel;

  int total = 0;
  int bad   = 0;

  // Model state
  int          ptr_m;
  bit          outv_m;
  logic [7:0]  out_m;
  int          och_m;

  arbitrated_n_channel_mux_module #(
    .BITS     (BITS),
    .CHANNELS (CHANNELS)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .data        (data),
    .valid       (valid),
    .ready       (ready),
    .mode        (mode),
    .select      (select),
    .out         (out),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_channel (out_channel)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    ptr_m  = 0;
    outv_m = 0;
    out_m  = '0;
    och_m  = 0;
  endtask

  task automatic rand_data();
    for (int i = 0; i < CHANNELS; i++) data[i] = 8'($urandom);
  endtask

  // One clock: check ready before the edge, advance model, check outputs after.
  task automatic cycle();
    logic [15:0] er;
    int          g;
    bit          fnd;
    bit          load;
    #1;
    er   = '0;
    fnd  = 0;
    g    = 0;
    load = !outv_m || out_ready;
    if (reset_n) begin
      if (mode) begin
        for (int i = 0; i < CHANNELS; i++) begin
          int c;
          c = (ptr_m + i) % CHANNELS;
          if (!fnd && valid[c]) begin
            fnd = 1;
            g   = c;
          end
        end
      end else if (int'(select) < CHANNELS && valid[select]) begin
        fnd = 1;
        g   = int'(select);
      end
      if (fnd && load) er[g] = 1'b1;
    end
    chk("ready", 32'(ready), 32'(er));
    @(posedge clk);
    if (!reset_n) begin
      model_reset();
    end else if (fnd && load) begin
      out_m  = data[g];
      och_m  = g;
      outv_m = 1;
      if (mode) ptr_m = (g + 1) % CHANNELS;
    end else if (load) begin
      outv_m = 0;
    end
    #1;
    chk("out_valid", 32'(out_valid), 32'(outv_m));
    chk("out", 32'(out), 32'(out_m));
    chk("out_channel", 32'(out_channel), 32'(och_m));
  endtask

  initial begin
    int rr_order [6] = '{0, 1, 15, 0, 1, 15};
    logic [7:0] held_out;
    logic [3:0] held_ch;

    // Reset with every channel requesting
    reset_n   = 1'b0;
    valid     = 16'hFFFF;
    out_ready = 1'b1;
    mode      = 1'b1;
    select    = '0;
    rand_data();
    model_reset();
    #1;
    chk("rst_ready", 32'(ready), 32'h0);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_out", 32'(out), 32'h0);
    cycle();
    cycle();
    reset_n = 1'b1;
    #1;
    chk("first_grant", 32'(ready), 32'h0001);

    // Round-robin wrap order with channels 0, 1, 15 requesting
    valid = 16'h8003;
    for (int k = 0; k < 6; k++) begin
      cycle();
      chk("rr_order", 32'(out_channel), 32'(rr_order[k]));
    end

    // Fixed select
    mode   = 1'b0;
    select = 4'd5;
    valid  = 16'h0020;
    data[5] = 8'hA5;
    #1;
    chk("fixed_ready", 32'(ready), 32'h0020);
    cycle();
    chk("fixed_out", 32'(out), 32'hA5);
    chk("fixed_ch", 32'(out_channel), 32'd5);
    chk("fixed_ov", 32'(out_valid), 32'h1);
    valid = 16'h0010;
    #1;
    chk("fixed_nogrant", 32'(ready), 32'h0);
    cycle();
    chk("fixed_idle", 32'(out_valid), 32'h0);

    // Backpressure with every channel requesting
    mode  = 1'b1;
    valid = 16'hFFFF;
    rand_data();
    cycle();
    held_out  = out_m;
    held_ch   = 4'(och_m);
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      rand_data();
      cycle();
      chk("bp_out_stable", 32'(out), 32'(held_out));
      chk("bp_ch_stable", 32'(out_channel), 32'(held_ch));
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", 32'(ready != '0), 32'h1);
    cycle();
    chk("bp_no_gap", 32'(out_valid), 32'h1);

    // Mid-stream reset with pointer at 7
    valid = 16'h0040;
    cycle();
    chk("ptr_setup_ch", 32'(out_channel), 32'd6);
    valid = 16'hFFFF;
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    chk("mid_rst_ov", 32'(out_valid), 32'h0);
    chk("mid_rst_ready", 32'(ready), 32'h0);
    cycle();
    reset_n = 1'b1;
    #1;
    chk("post_rst_grant", 32'(ready), 32'h0001);
    cycle();

    // Randomized traffic
    for (int k = 0; k < 400; k++) begin
      rand_data();
      case ($urandom_range(0, 3))
        0:       valid = 16'($urandom) & 16'($urandom);
        1:       valid = 16'($urandom);
        2:       valid = 16'h1 << $urandom_range(0, 15);
        default: valid = 16'hFFFF;
      endcase
      if ($urandom_range(0, 7) == 0) mode = ~mode;
      select    = 4'($urandom_range(0, 15));
      out_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/arbitrated_n_channel_mux_module.md
ARBITRATED_N_CHANNEL_MUX_MODULE -- requirements
Module: ARBITRATED_N_CHANNEL_MUX_MODULE

Interface
REQ-001 Parameter BITS, default 32, data width per channel; legal range >= 1.
REQ-002 Parameter CHANNELS, default 16, number of input channels; legal range 2..64; need not be a power of two.
REQ-003 Derived constant SEL_W = max(1, clog2(CHANNELS)), the width of channel indices.
REQ-004 CLK  in  1  sole clock; all state updates on the rising edge.
REQ-005 RESET_N  in  1  asynchronous, active-low reset.
REQ-006 DATA  in  [CHANNELS-1:0][BITS-1:0]  packed per-channel input data.
REQ-007 VALID  in  CHANNELS  per-channel request; channel i offers DATA[i] while VALID[i]=1.
REQ-008 READY  out  CHANNELS  per-channel accept strobe; combinational; at most one bit set.
REQ-009 MODE  in  1  0 = fixed select (SELECT chooses the channel), 1 = round-robin arbitration.
REQ-010 SELECT  in  SEL_W  channel index used in MODE=0; ignored in MODE=1.
REQ-011 OUT  out  BITS  registered selected data.
REQ-012 OUT_VALID  out  1  OUT holds an unconsumed word.
REQ-013 OUT_READY  in  1  downstream accepts OUT when OUT_VALID=1.
REQ-014 OUT_CHANNEL  out  SEL_W  registered index of the channel that supplied OUT.

Function
REQ-015 LOAD = !OUT_VALID || OUT_READY; a transfer from channel g occurs in a cycle only when LOAD=1, g is granted and VALID[g]=1.
REQ-016 READY[g] = 1 exactly in cycles where the transfer of REQ-015 occurs; all other READY bits = 0.
REQ-017 MODE=0: grant candidate is SELECT; SELECT >= CHANNELS produces no grant.
REQ-018 MODE=1: grant goes to the first i with VALID[i]=1 scanning PTR, PTR+1, ... wrapping modulo CHANNELS; no grant if VALID = 0.
REQ-019 Internal pointer PTR (SEL_W bits): on a MODE=1 transfer from g, PTR <= (g+1) mod CHANNELS (g = CHANNELS-1 wraps to 0); PTR holds otherwise, including during all MODE=0 cycles.
REQ-020 On transfer: OUT <= DATA[g], OUT_CHANNEL <= g, OUT_VALID <= 1 at the next edge; latency is one cycle from VALID/READY to OUT_VALID.
REQ-021 If LOAD=1 and no transfer occurs, OUT_VALID <= 0; OUT and OUT_CHANNEL hold their last values.
REQ-022 While OUT_VALID=1 and OUT_READY=0, OUT, OUT_CHANNEL and OUT_VALID hold and all READY bits are 0 (backpressure).
REQ-023 Simultaneous OUT_READY=1 and a new transfer in one cycle: the held word is consumed and the new word loads at the same edge; full throughput of one word per cycle is sustained.
REQ-024 MODE or SELECT change takes effect on the next grant decision; a word already held in OUT is unaffected.
REQ-025 Channel with VALID=1 but no grant keeps its data; the block never drops or duplicates a word.

Reset
REQ-026 RESET_N low asynchronously forces OUT=0, OUT_VALID=0, OUT_CHANNEL=0, PTR=0.
REQ-027 All READY bits SHALL be 0 while RESET_N is low; normal operation resumes on the first rising CLK edge after RESET_N rises.
REQ-028 Reset asserted mid-stream discards the held word; no transfer is reported for the cycle in which reset is asserted.

Structure
REQ-029 Shared package MUX_PKG holds the MODE encoding constants (MODE_FIXED=0, MODE_ROUND_ROBIN=1) and the SEL_W derivation function.
REQ-030 The rotating find-first search is one combinational sub-module ROUND_ROBIN_PRIORITY_ENCODER_MODULE #(CHANNELS) (inputs: request vector, PTR; outputs: grant index, grant-found flag).
REQ-031 Data selection by grant index is a parametrised indexed selection over DATA; no fixed-size mux trees.

Verification (CHANNELS=16, BITS=8)
REQ-032 Reset: RESET_N=0 with VALID=16'hFFFF, OUT_READY=1 -> READY=0, OUT_VALID=0, OUT=0; release -> first grant is channel 0.
REQ-033 Fixed mode: MODE=0, SELECT=5, VALID=16'h0020, DATA[5]=8'hA5, OUT_READY=1 -> READY=16'h0020, next cycle OUT=8'hA5, OUT_CHANNEL=5, OUT_VALID=1; VALID[5]=0 with VALID[4]=1 -> no grant.
REQ-034 Round-robin fairness/wrap: MODE=1, VALID=16'h8003 held, OUT_READY=1 -> grant order 0,1,15,0,1,15; PTR wraps 15->0.
REQ-035 Backpressure: word held with OUT_READY=0 for 3 cycles while VALID=16'hFFFF -> READY=0, OUT/OUT_CHANNEL stable; OUT_READY=1 -> consume and reload same edge, no gap.
REQ-036 Mid-stream reset: RESET_N pulsed low while OUT_VALID=1 and PTR=7 -> OUT_VALID=0, PTR=0, next MODE=1 grant with VALID=16'hFFFF is channel 0.
